// File: rtl/sync_fifo_pkg.sv
// Shared defaults and derived sizing constants for the synchronous FIFO.
package sync_fifo_pkg;

    localparam int DATA_WIDTH_DEF = 8;
    localparam int ADDR_WIDTH_DEF = 4;
    localparam int AEMPTY_LVL_DEF = 2;

    function automatic int fifo_depth(input int addr_width);
        return 2 ** addr_width;
    endfunction

    function automatic int fifo_cnt_width(input int addr_width);
        return addr_width + 1;
    endfunction

    localparam int DEPTH_DEF      = fifo_depth(ADDR_WIDTH_DEF);
    localparam int CNT_WIDTH_DEF  = fifo_cnt_width(ADDR_WIDTH_DEF);
    localparam int AFULL_LVL_DEF  = DEPTH_DEF - 2;

endpackage

// File: rtl/sync_fifo_ram.sv
// Simple dual-port storage: one write port and one registered read port.
// Only the read register is reset; the array itself keeps its contents.
module sync_fifo_ram #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic                  re,
    input  logic [ADDR_WIDTH-1:0] raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem [0:(2**ADDR_WIDTH)-1];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // rdata holds its value whenever no read is accepted.
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/sync_fifo_valid.sv
// Synchronous FIFO with registered read data, a one-cycle valid strobe,
// occupancy flags and sticky overflow/underflow indicators.
module sync_fifo_valid
    import sync_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
    parameter int AFULL_LVL  = fifo_depth(ADDR_WIDTH) - 2,
    parameter int AEMPTY_LVL = AEMPTY_LVL_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  valid,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  overflow,
    output logic                  underflow
);

    localparam int                DEPTH    = fifo_depth(ADDR_WIDTH);
    localparam logic [ADDR_WIDTH:0] DEPTH_C  = DEPTH[ADDR_WIDTH:0];
    localparam logic [ADDR_WIDTH:0] AFULL_C  = AFULL_LVL[ADDR_WIDTH:0];
    localparam logic [ADDR_WIDTH:0] AEMPTY_C = AEMPTY_LVL[ADDR_WIDTH:0];

    logic [ADDR_WIDTH-1:0] wr_ptr;
    logic [ADDR_WIDTH-1:0] rd_ptr;
    logic                  wr_acc;
    logic                  rd_acc;

    // Handshake: a request is accepted on the edge where wr_en && !full
    // (write) or rd_en && !empty (read); valid is high for exactly the one
    // cycle after an accepted read, while rdata carries that word.
    assign wr_acc = wr_en && !full;
    assign rd_acc = rd_en && !empty;

    assign full         = (count == DEPTH_C);
    assign empty        = (count == '0);
    assign almost_full  = (count >= AFULL_C);
    assign almost_empty = (count <= AEMPTY_C);

    sync_fifo_ram #(
        .DATA_WIDTH(DATA_WIDTH),
        .ADDR_WIDTH(ADDR_WIDTH)
    ) u_ram (
        .clk   (clk),
        .rst   (rst),
        .we    (wr_acc && !rst),
        .waddr (wr_ptr),
        .wdata (wdata),
        .re    (rd_acc),
        .raddr (rd_ptr),
        .rdata (rdata)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            valid     <= 1'b0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            valid <= rd_acc;
            if (wr_acc) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (rd_acc) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({wr_acc, rd_acc})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (wr_en && full) begin
                overflow <= 1'b1;
            end
            if (rd_en && empty) begin
                underflow <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_sync_fifo_valid.sv
// Directed bench for sync_fifo_valid with DATA_WIDTH=8, ADDR_WIDTH=4,
// AFULL_LVL=14, AEMPTY_LVL=2.
module tb_sync_fifo_valid;

    logic       clk = 1'b0;
    logic       rst;
    logic       wr_en;
    logic [7:0] wdata;
    logic       rd_en;
    logic [7:0] rdata;
    logic       valid;
    logic       full;
    logic       empty;
    logic       almost_full;
    logic       almost_empty;
    logic [4:0] count;
    logic       overflow;
    logic       underflow;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    sync_fifo_valid #(
        .DATA_WIDTH(8),
        .ADDR_WIDTH(4),
        .AFULL_LVL (14),
        .AEMPTY_LVL(2)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .wr_en        (wr_en),
        .wdata        (wdata),
        .rd_en        (rd_en),
        .rdata        (rdata),
        .valid        (valid),
        .full         (full),
        .empty        (empty),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .count        (count),
        .overflow     (overflow),
        .underflow    (underflow)
    );

    // Inputs change on the falling edge; outputs are checked on the next one.
    task automatic cycle();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1; wr_en = 1'b0; rd_en = 1'b0; wdata = 8'h00;
        cycle();
        rst = 1'b0;
    endtask

    task automatic push(input logic [7:0] d);
        wr_en = 1'b1; rd_en = 1'b0; wdata = d;
        cycle();
        wr_en = 1'b0;
    endtask

    task automatic pop_chk(input string tag, input logic [7:0] d);
        rd_en = 1'b1; wr_en = 1'b0;
        cycle();
        rd_en = 1'b0;
        chk({tag, "_valid"}, 32'(valid), 32'd1);
        chk({tag, "_rdata"}, 32'(rdata), 32'(d));
    endtask

    initial begin
        rst = 1'b1; wr_en = 1'b0; rd_en = 1'b0; wdata = 8'h00;
        @(negedge clk);
        cycle();
        cycle();
        rst = 1'b0;

        // Reset state
        chk("rst_count",  32'(count), 32'd0);
        chk("rst_empty",  32'(empty), 32'd1);
        chk("rst_aempty", 32'(almost_empty), 32'd1);
        chk("rst_full",   32'(full), 32'd0);
        chk("rst_afull",  32'(almost_full), 32'd0);
        chk("rst_valid",  32'(valid), 32'd0);
        chk("rst_rdata",  32'(rdata), 32'd0);
        chk("rst_ovf",    32'(overflow), 32'd0);
        chk("rst_udf",    32'(underflow), 32'd0);

        // Fill with 0x01..0x10
        for (int i = 1; i <= 16; i++) begin
            push(8'(i));
            chk("fill_count",  32'(count), 32'(i));
            chk("fill_afull",  32'(almost_full), (i >= 14) ? 32'd1 : 32'd0);
            chk("fill_aempty", 32'(almost_empty), (i <= 2) ? 32'd1 : 32'd0);
            chk("fill_full",   32'(full), (i == 16) ? 32'd1 : 32'd0);
            chk("fill_empty",  32'(empty), 32'd0);
        end

        // Write while full is dropped
        push(8'hAA);
        chk("ovf_flag",  32'(overflow), 32'd1);
        chk("ovf_count", 32'(count), 32'd16);
        chk("ovf_full",  32'(full), 32'd1);

        // Drain in order, valid one cycle after each read
        for (int i = 1; i <= 16; i++) begin
            pop_chk("drain", 8'(i));
            chk("drain_count", 32'(count), 32'(16 - i));
        end
        cycle();
        chk("idle_valid", 32'(valid), 32'd0);
        chk("idle_rdata", 32'(rdata), 32'h10);
        chk("idle_udf",   32'(underflow), 32'd0);
        chk("idle_ovf",   32'(overflow), 32'd1);

        // Read while empty
        rd_en = 1'b1;
        cycle();
        rd_en = 1'b0;
        chk("udf_valid", 32'(valid), 32'd0);
        chk("udf_rdata", 32'(rdata), 32'h10);
        chk("udf_flag",  32'(underflow), 32'd1);
        chk("udf_count", 32'(count), 32'd0);
        chk("udf_empty", 32'(empty), 32'd1);

        // Pointer wrap
        for (int i = 0; i < 10; i++) push(8'h30 + 8'(i));
        for (int i = 0; i < 10; i++) pop_chk("wrap_a", 8'h30 + 8'(i));
        for (int i = 0; i < 12; i++) push(8'h20 + 8'(i));
        chk("wrap_count12", 32'(count), 32'd12);
        for (int i = 0; i < 12; i++) pop_chk("wrap_b", 8'h20 + 8'(i));
        chk("wrap_count0", 32'(count), 32'd0);
        chk("wrap_empty",  32'(empty), 32'd1);

        // Simultaneous write and read while empty: no fall-through
        do_reset();
        cycle();
        chk("sim_e_udf0", 32'(underflow), 32'd0);
        wr_en = 1'b1; rd_en = 1'b1; wdata = 8'h55;
        cycle();
        wr_en = 1'b0; rd_en = 1'b0;
        chk("sim_e_count", 32'(count), 32'd1);
        chk("sim_e_valid", 32'(valid), 32'd0);
        chk("sim_e_rdata", 32'(rdata), 32'd0);
        chk("sim_e_udf",   32'(underflow), 32'd1);
        pop_chk("sim_e_pop", 8'h55);
        chk("sim_e_count0", 32'(count), 32'd0);

        // Simultaneous write and read while full: read wins
        for (int i = 0; i < 16; i++) push(8'h80 + 8'(i));
        chk("sim_f_full", 32'(full), 32'd1);
        chk("sim_f_ovf0", 32'(overflow), 32'd0);
        wr_en = 1'b1; rd_en = 1'b1; wdata = 8'hEE;
        cycle();
        chk("sim_f_valid", 32'(valid), 32'd1);
        chk("sim_f_rdata", 32'(rdata), 32'h80);
        chk("sim_f_count", 32'(count), 32'd15);
        chk("sim_f_ovf",   32'(overflow), 32'd1);

        // Simultaneous accepted read and write: count holds
        wdata = 8'hEF;
        cycle();
        wr_en = 1'b0; rd_en = 1'b0;
        chk("sim_m_rdata", 32'(rdata), 32'h81);
        chk("sim_m_count", 32'(count), 32'd15);
        for (int i = 2; i < 16; i++) pop_chk("sim_m_pop", 8'h80 + 8'(i));
        pop_chk("sim_m_popef", 8'hEF);
        chk("sim_m_empty", 32'(empty), 32'd1);

        // Reset mid-operation dominates a concurrent write
        do_reset();
        for (int i = 0; i < 7; i++) push(8'h60 + 8'(i));
        chk("mid_count7", 32'(count), 32'd7);
        rst = 1'b1; wr_en = 1'b1; wdata = 8'h77;
        cycle();
        rst = 1'b0; wr_en = 1'b0;
        chk("mid_count",  32'(count), 32'd0);
        chk("mid_empty",  32'(empty), 32'd1);
        chk("mid_aempty", 32'(almost_empty), 32'd1);
        chk("mid_full",   32'(full), 32'd0);
        chk("mid_afull",  32'(almost_full), 32'd0);
        chk("mid_valid",  32'(valid), 32'd0);
        chk("mid_rdata",  32'(rdata), 32'd0);
        chk("mid_ovf",    32'(overflow), 32'd0);
        chk("mid_udf",    32'(underflow), 32'd0);
        rd_en = 1'b1;
        cycle();
        rd_en = 1'b0;
        chk("mid_discard_valid", 32'(valid), 32'd0);
        chk("mid_discard_udf",   32'(underflow), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: observed no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/sync_fifo_valid.md
SYNC_FIFO_VALID -- requirements
Module: sync_fifo_valid

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, the data word width in bits.
REQ-002 SHALL have parameter ADDR_WIDTH, default 4, the pointer width; DEPTH = 2**ADDR_WIDTH entries.
REQ-003 SHALL have parameter AFULL_LVL, default DEPTH-2, the count at or above which almost_full asserts.
REQ-004 SHALL have parameter AEMPTY_LVL, default 2, the count at or below which almost_empty asserts.
REQ-005 SHALL have ports as below; one clock; reset is synchronous and active-high.
- clk  in  1  sole clock, rising edge
- rst  in  1  synchronous active-high reset
- wr_en  in  1  write request
- wdata  in  DATA_WIDTH  write data
- rd_en  in  1  read request
- rdata  out  DATA_WIDTH  registered read data
- valid  out  1  rdata updated by an accepted read this cycle
- full  out  1  count == DEPTH
- empty  out  1  count == 0
- almost_full  out  1  count >= AFULL_LVL
- almost_empty  out  1  count <= AEMPTY_LVL
- count  out  ADDR_WIDTH+1  occupancy, 0..DEPTH
- overflow  out  1  sticky: write requested while full
- underflow  out  1  sticky: read requested while empty

Function
REQ-006 Write accepted iff wr_en && !full: mem[wr_ptr] <= wdata, wr_ptr increments by 1.
REQ-007 Read accepted iff rd_en && !empty: rdata <= mem[rd_ptr] next edge, rd_ptr increments, valid = 1 for exactly that cycle.
REQ-008 Read latency SHALL be 1 cycle: data requested at edge N is on rdata with valid high after edge N+1.
REQ-009 With no accepted read, valid SHALL be 0 and rdata SHALL hold its last value.
REQ-010 Pointers SHALL be ADDR_WIDTH bits and wrap from DEPTH-1 to 0 with no special handling.
REQ-011 count SHALL be +1 on write-only, -1 on read-only, unchanged on both or neither accepted.
REQ-012 full, empty, almost_full, almost_empty SHALL derive combinationally from the count register.
REQ-013 Simultaneous wr_en and rd_en while empty: write accepted, read rejected (no fall-through), underflow sets.
REQ-014 Simultaneous wr_en and rd_en while full: read accepted, write rejected, overflow sets, count ends DEPTH-1.
REQ-015 Simultaneous accepted read and write otherwise: both proceed, count unchanged.
REQ-016 Rejected write SHALL not modify memory or wr_ptr; rejected read SHALL not modify rdata, rd_ptr, or valid (valid stays 0).
REQ-017 overflow and underflow SHALL remain set until rst; they never block operation.
REQ-018 Parameter legality: 0 < AEMPTY_LVL < AFULL_LVL < DEPTH; the block is not required to check it.

Reset
REQ-019 On rst at a clock edge: wr_ptr, rd_ptr, count = 0; rdata = 0; valid, overflow, underflow = 0.
REQ-020 After reset: empty = 1, almost_empty = 1, full = 0, almost_full = 0.
REQ-021 Memory contents SHALL not be reset.
REQ-022 rst SHALL dominate wr_en/rd_en in the same cycle; a mid-operation reset discards all stored data.

Structure
REQ-023 Parameter defaults and the derived DEPTH/count-width constants SHALL live in a shared package sync_fifo_pkg.
REQ-024 Storage SHALL be one sub-module, sync_fifo_ram: one write port, one registered read port, same clock, no reset on the array.
REQ-025 Pointer, count, flag, and sticky-error logic SHALL reside in sync_fifo_valid.

Verification (DATA_WIDTH=8, ADDR_WIDTH=4, AFULL_LVL=14, AEMPTY_LVL=2)
REQ-026 Reset, then write 0x01..0x10 -> full=1 after 16th write, count=16, almost_full from count 14, almost_empty clears at count 3.
REQ-027 From full, 17th write 0xAA -> rejected, overflow=1, count=16, later reads return 0x01..0x10 in order, valid one cycle after each rd_en.
REQ-028 Read when empty -> valid=0, rdata unchanged, underflow=1, count=0.
REQ-029 Wrap: write 10 words, read 10, write 0x20..0x2B, read 12 -> data in order, count returns to 0, empty=1.
REQ-030 Empty with wr_en=rd_en=1 and wdata=0x55 -> count=1, valid=0, underflow=1; next cycle rd_en -> rdata=0x55, valid=1.
REQ-031 rst asserted at count=7 alongside wr_en -> next cycle count=0, empty=1, flags and valid cleared, write discarded.
